// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encodings and counter-width helper for the serial arithmetic blocks
package serial_adder_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int cnt_width(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: load/done handshake and result bus of the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (output start, a_in, b_in, cin, input sum, cout, busy, done);
    modport slave  (input start, a_in, b_in, cin, output sum, cout, busy, done);
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: 1-bit combinational full adder, counterpart of the subtractor cell
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, {cout,sum} = a_in + b_in + cin after WIDTH cycles
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry;
    logic             cout_q;
    logic             s_bit;
    logic             c_bit;
    logic             accept;

    full_adder_cell u_cell (.x(a_q[0]), .y(b_q[0]), .z(carry), .s(s_bit), .c(c_bit));

    assign accept = bus.start && (state != ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a_in;
            b_q   <= bus.b_in;
            carry <= bus.cin;
            cnt   <= '0;
            state <= ST_SHIFT;
        end else if (state == ST_SHIFT) begin
            s_q   <= {s_bit, s_q[WIDTH-1:1]};
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            carry <= c_bit;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                cout_q <= c_bit;
                cnt    <= '0;
                state  <= ST_DONE;
            end
        end else begin
            state <= ST_IDLE;
        end
    end

    assign bus.sum  = s_q;
    assign bus.cout = cout_q;
    assign bus.busy = (state == ST_SHIFT);
    assign bus.done = (state == ST_DONE);
endmodule
